nn_weight_loader: RTL

//  Writer side of the feed-forward NN weight RAM. Accepts a stream of signed

---
 rtl/nn_weight_loader.sv | 87 ++++++++
 1 files changed

// File: rtl/nn_weight_loader.sv
// nn_weight_loader: packs a stream of signed weights into RAM words written at consecutive addresses
module nn_weight_loader #(
   parameter int WWIDTH   = 8,
   parameter int NWEIGHTS = 32,
   parameter int AW       = 4,
   parameter int DW       = WWIDTH * NWEIGHTS
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [AW-1:0]     base_addr,
   input  logic [AW:0]       num_words,
   input  logic [WWIDTH-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [AW-1:0]     mem_addr,
   output logic [DW-1:0]     mem_wdata,
   output logic              mem_we,
   output logic              busy,
   output logic              done,
   output logic [WWIDTH-1:0] checksum
);
   localparam int BW = NWEIGHTS > 1 ? $clog2(NWEIGHTS) : 1;
   typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;
   state_t state, state_nx;
   logic [AW-1:0] base, word_idx;
   logic [AW:0] nwords;
   logic [BW-1:0] beat;
   logic [DW-1:0] fill_q, fill_nx;
   logic accept, last_beat, last_word;
   assign accept    = in_valid && in_ready;
   assign last_beat = accept && beat == BW'(NWEIGHTS - 1);
   assign last_word = {1'b0, word_idx} == nwords - (AW+1)'(1);
   always_ff @(posedge clk)
      if (reset) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = num_words == '0 ? DONE : FILL;
         FILL:    if (last_beat) state_nx = WRITE;
         WRITE:   state_nx = last_word ? DONE : FILL;
         default: state_nx = IDLE;
      endcase
   end
   always_comb begin
      in_ready = state == FILL;
      mem_we   = state == WRITE;
      busy     = state != IDLE;
      done     = state == DONE;
   end
   // The word is assembled in a separate buffer so mem_wdata only changes when a word completes
   always_comb begin
      fill_nx = fill_q;
      fill_nx[beat*WWIDTH +: WWIDTH] = in_data;
   end
   always_ff @(posedge clk)
      if (reset) begin
         base      <= '0;
         nwords    <= '0;
         word_idx  <= '0;
         beat      <= '0;
         fill_q    <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         checksum  <= '0;
      end else begin
         if (state == IDLE && start) begin
            base     <= base_addr;
            nwords   <= num_words;
            word_idx <= '0;
            beat     <= '0;
            checksum <= '0;
         end
         if (accept) begin
            fill_q   <= fill_nx;
            beat     <= beat + BW'(1);
            checksum <= checksum + in_data;
         end
         if (last_beat) begin
            mem_wdata <= fill_nx;
            mem_addr  <= base + word_idx;
            beat      <= '0;
         end
         if (state == WRITE && !last_word) word_idx <= word_idx + AW'(1);
      end
endmodule
